// File: rtl/seg_mux_ctrl.sv
// Time-multiplexed N-digit 7-segment driver: one digit per refresh slot, an all-off guard
// at each slot start, and double-buffered frame data that swaps only at the frame boundary.
module seg_mux_ctrl #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int GUARD          = 2000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_SUPPRESS    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   disp_vals,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [N_DIGITS-1:0]     an_out,
    output logic                    frame_done
);

    localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0]   GUARD_END = TICK_W'(GUARD);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic                SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic                AN_INV    = (AN_ACTIVE_LOW != 0);
    localparam logic                LZ_EN     = (LZ_SUPPRESS != 0);
    localparam logic [6:0]          SEG_OFF   = {7{SEG_INV}};
    localparam logic                DP_OFF    = SEG_INV;
    localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_INV}};

    // Active-high segment pattern {a,b,c,d,e,f,g} for a hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h7E;
            4'h1:    pat = 7'h30;
            4'h2:    pat = 7'h6D;
            4'h3:    pat = 7'h79;
            4'h4:    pat = 7'h33;
            4'h5:    pat = 7'h5B;
            4'h6:    pat = 7'h5F;
            4'h7:    pat = 7'h70;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h73;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h1F;
            4'hC:    pat = 7'h4E;
            4'hD:    pat = 7'h3D;
            4'hE:    pat = 7'h4F;
            4'hF:    pat = 7'h47;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Digit i is a suppressed leading zero when it and every digit to its left are zero.
    function automatic logic [N_DIGITS-1:0] lz_mask(input logic [4*N_DIGITS-1:0] vals);
        logic [N_DIGITS-1:0] mask;
        logic                zero_run;
        mask     = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (vals[4*i +: 4] == 4'h0);
            mask[i]  = LZ_EN & (i != 0) & zero_run;
        end
        return mask;
    endfunction

    logic [TICK_W-1:0]     tick_r;
    logic [IDX_W-1:0]      idx_r;
    logic [4*N_DIGITS-1:0] pend_vals_r;
    logic [N_DIGITS-1:0]   pend_dp_r;
    logic [N_DIGITS-1:0]   pend_blank_r;
    logic [4*N_DIGITS-1:0] act_vals_r;
    logic [N_DIGITS-1:0]   act_dp_r;
    logic [N_DIGITS-1:0]   act_blank_r;

    logic                  slot_end_s;
    logic                  wrap_s;
    logic [N_DIGITS-1:0]   lz_dark_s;
    logic [3:0]            nib_s;
    logic                  dp_sel_s;
    logic                  dark_s;
    logic [N_DIGITS-1:0]   an_sel_s;

    assign slot_end_s = en & (tick_r == TICK_LAST);
    assign wrap_s     = slot_end_s & (idx_r == IDX_LAST);
    assign lz_dark_s  = lz_mask(act_vals_r);

    // Select the active frame data for the digit currently being scanned.
    always_comb begin
        nib_s    = 4'h0;
        dp_sel_s = 1'b0;
        dark_s   = 1'b1;
        an_sel_s = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                nib_s       = act_vals_r[4*i +: 4];
                dp_sel_s    = act_dp_r[i];
                dark_s      = act_blank_r[i] | lz_dark_s[i];
                an_sel_s[i] = 1'b1;
            end else begin
                an_sel_s[i] = 1'b0;
            end
        end
    end

    // Slot tick counter and scanned-digit index; both freeze while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= '0;
            idx_r  <= '0;
        end else if (en) begin
            if (tick_r == TICK_LAST) begin
                tick_r <= '0;
                idx_r  <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
            end else begin
                tick_r <= tick_r + TICK_W'(1);
                idx_r  <= idx_r;
            end
        end else begin
            tick_r <= tick_r;
            idx_r  <= idx_r;
        end
    end

    // Pending frame captures every load; active frame changes only on the wrap edge,
    // taking a same-edge load directly so it is not delayed a whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vals_r  <= '0;
            pend_dp_r    <= '0;
            pend_blank_r <= '1;
            act_vals_r   <= '0;
            act_dp_r     <= '0;
            act_blank_r  <= '1;
        end else begin
            if (load) begin
                pend_vals_r  <= disp_vals;
                pend_dp_r    <= dp_in;
                pend_blank_r <= blank;
            end else begin
                pend_vals_r  <= pend_vals_r;
                pend_dp_r    <= pend_dp_r;
                pend_blank_r <= pend_blank_r;
            end
            if (wrap_s) begin
                act_vals_r  <= load ? disp_vals : pend_vals_r;
                act_dp_r    <= load ? dp_in     : pend_dp_r;
                act_blank_r <= load ? blank     : pend_blank_r;
            end else begin
                act_vals_r  <= act_vals_r;
                act_dp_r    <= act_dp_r;
                act_blank_r <= act_blank_r;
            end
        end
    end

    // Registered pin drive: dark during reset, pause and guard; dark digits keep their anode.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            seg_out    <= SEG_OFF;
            dp_out     <= DP_OFF;
            an_out     <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap_s;
            if (tick_r < GUARD_END) begin
                seg_out <= SEG_OFF;
                dp_out  <= DP_OFF;
                an_out  <= AN_OFF;
            end else begin
                an_out  <= an_sel_s ^ AN_OFF;
                seg_out <= dark_s ? SEG_OFF : (seg_decode(nib_s) ^ SEG_OFF);
                dp_out  <= dark_s ? DP_OFF  : (dp_sel_s ^ DP_OFF);
            end
        end
    end

endmodule
